// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared states, default sizing and index-width helper for wide_add_seq
package wide_add_pkg;
   localparam int CHUNK_DEF = 4;
   localparam int CHUNKS_DEF = 4;
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t RUN = 2'd1;
   localparam state_t DONE = 2'd2;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rca_slice.sv
// rca_slice: SIZE-bit ripple-carry adder built from generate/propagate grey cells
module rca_slice #(
   parameter int SIZE = 4
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            cin,
   output logic [SIZE-1:0] s,
   output logic            cout
);
   logic [SIZE-1:0] g, p;
   logic [SIZE:0] c;
   assign g = a & b;
   assign p = a ^ b;
   assign c[0] = cin;
   for (genvar i = 0; i < SIZE; i++) begin : g_chain
      assign c[i+1] = g[i] | (p[i] & c[i]);
   end
   assign s = p ^ c[SIZE-1:0];
   assign cout = c[SIZE];
endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: W-bit add/subtract done one CHUNK-bit slice per cycle with registered carry
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int CHUNK = CHUNK_DEF,
   parameter int CHUNKS = CHUNKS_DEF,
   localparam int W = CHUNK * CHUNKS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         zero,
   output logic         busy
);
   localparam int IW = idx_w(CHUNKS);
   state_t state;
   logic [W-1:0] a_r, b_r, sum_n;
   logic [IW-1:0] idx;
   logic carry_r, s_cout, last;
   logic [CHUNK-1:0] s_sum;
   rca_slice #(.SIZE(CHUNK)) u_slice (
      .a(a_r[idx*CHUNK +: CHUNK]),
      .b(b_r[idx*CHUNK +: CHUNK]),
      .cin(carry_r),
      .s(s_sum),
      .cout(s_cout)
   );
   assign last = idx == IW'(CHUNKS - 1);
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   assign busy = state != IDLE;
   // zero must see the final chunk, which only lands in sum at the same edge
   always_comb begin
      sum_n = sum;
      sum_n[idx*CHUNK +: CHUNK] = s_sum;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         a_r <= '0;
         b_r <= '0;
         idx <= '0;
         carry_r <= 1'b0;
         sum <= '0;
         cout <= 1'b0;
         zero <= 1'b0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            a_r <= a;
            b_r <= sub ? ~b : b;
            carry_r <= cin ^ sub;
            idx <= '0;
            sum <= '0;
            state <= RUN;
         end
      end else if (state == RUN) begin
         sum <= sum_n;
         carry_r <= s_cout;
         if (last) begin
            state <= DONE;
            cout <= s_cout;
            zero <= sum_n == '0;
         end else idx <= idx + 1'b1;
      end else if (out_ready) state <= IDLE;
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: directed checks of wide_add_seq at CHUNK=4, CHUNKS=4
module tb_wide_add_seq;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic in_ready, out_valid, cout, zero, busy;
   logic [15:0] sum;
   int n_cmp = 0, n_bad = 0, cyc = 0;
   int acc_q[$];
   logic [16:0] res_q[$];
   wide_add_seq #(.CHUNK(4), .CHUNKS(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .zero(zero), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (in_valid && in_ready) acc_q.push_back(cyc);
   always @(posedge clk) if (out_valid && out_ready) res_q.push_back({cout, sum});
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic [15:0] ai, input logic [15:0] bi, input logic ci, input logic si);
      a = ai;
      b = bi;
      cin = ci;
      sub = si;
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !in_ready; t++) step();
      step();
      in_valid = 1'b0;
   endtask
   task automatic collect(input string tag, input logic [15:0] es, input logic ec, input logic ez);
      int lat = 0;
      while (!out_valid && lat < 50) begin
         step();
         lat++;
      end
      chk({tag, ".lat"}, lat, 4);
      chk({tag, ".sum"}, sum, es);
      chk({tag, ".cout"}, cout, ec);
      chk({tag, ".zero"}, zero, ez);
      chk({tag, ".rdy_dv"}, {in_ready, out_valid}, 2'b01);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, ".idle"}, {in_ready, out_valid, busy}, 3'b100);
   endtask
   initial begin
      #2;
      chk("rst.flags", {in_ready, out_valid, busy, cout, zero}, 5'b10000);
      chk("rst.sum", sum, 16'h0);
      #10 rst_n = 1'b1;
      step();
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      collect("add_ripple", 16'h0000, 1'b1, 1'b1);
      issue(16'h0FFF, 16'h0000, 1'b1, 1'b0);
      collect("add_cin", 16'h1000, 1'b0, 1'b0);
      issue(16'h1234, 16'h0235, 1'b0, 1'b1);
      collect("sub", 16'h0FFF, 1'b1, 1'b0);
      issue(16'h0001, 16'h0002, 1'b0, 1'b1);
      collect("sub_under", 16'hFFFF, 1'b0, 1'b0);
      issue(16'h0010, 16'h0001, 1'b1, 1'b1);
      collect("sub_bin", 16'h000E, 1'b1, 1'b0);
      issue(16'h5555, 16'h5555, 1'b0, 1'b1);
      collect("sub_zero", 16'h0000, 1'b1, 1'b1);
      // backpressure: result held while new operands are offered
      issue(16'h1234, 16'h0235, 1'b0, 1'b0);
      for (int t = 0; t < 50 && !out_valid; t++) step();
      for (int k = 0; k < 10; k++) begin
         in_valid = k[0];
         a = 16'hAAAA ^ 16'(k);
         b = 16'h5555;
         step();
         chk("bp.hold", {in_ready, out_valid, cout, zero, sum}, {4'b0100, 16'h1469});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp.release", {in_ready, out_valid}, 2'b10);
      // reset in the middle of an operation
      issue(16'h1111, 16'h2222, 1'b0, 1'b0);
      step();
      step();
      chk("mid.busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid.rst", {in_ready, out_valid, busy, cout, zero, sum}, {5'b10000, 16'h0});
      #2 rst_n = 1'b1;
      step();
      issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
      collect("post_rst", 16'h0100, 1'b0, 1'b0);
      // back-to-back throughput
      acc_q.delete();
      res_q.delete();
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a = (k == 0) ? 16'h0101 : (k == 1) ? 16'h8000 : 16'h4000;
         b = (k == 0) ? 16'h0202 : (k == 1) ? 16'h8000 : 16'h0001;
         sub = k == 2;
         for (int t = 0; t < 50 && acc_q.size() < k + 1; t++) step();
      end
      in_valid = 1'b0;
      sub = 1'b0;
      for (int t = 0; t < 50 && res_q.size() < 3; t++) step();
      out_ready = 1'b0;
      chk("tp.n_acc", acc_q.size(), 3);
      chk("tp.n_res", res_q.size(), 3);
      if (acc_q.size() == 3) begin
         chk("tp.gap0", acc_q[1] - acc_q[0], 6);
         chk("tp.gap1", acc_q[2] - acc_q[1], 6);
      end
      if (res_q.size() == 3) begin
         chk("tp.res0", res_q[0], {1'b0, 16'h0303});
         chk("tp.res1", res_q[1], {1'b1, 16'h0000});
         chk("tp.res2", res_q[2], {1'b1, 16'h3FFF});
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
